// File: rtl/ped_cond_pkg.sv
// Shared types and default parameter values for the pedestrian request conditioner
// and its input debouncer.
package ped_cond_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    SERVING  = 2'd2,
    COOLDOWN = 2'd3
  } ped_state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_COOLDOWN_CYCLES = 8;
  localparam int DEF_MAX_WAIT        = 1024;
  localparam int DEF_COUNT_WIDTH     = 16;

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchroniser plus debounce counter for a bouncing push-button; emits the
// debounced level and a one-cycle pulse on each debounced rising transition.
module button_debouncer
  import ped_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic button_raw,
  output logic stable,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;
  logic             flip;

  // The flip is decided combinationally so press lines up with the edge that updates stable.
  assign flip  = (sync2 != stable) && (cnt == CNT_LAST);
  assign press = flip && sync2;

  // NOTE: non-blocking assignments here so sync2 samples the old sync1 at each edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      sync1 <= button_raw;
      sync2 <= sync1;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (flip) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pedestrian_request_conditioner.sv
// Turns the raw crossing button into a held request for the pedestrian arbiter, with
// WAIT lamp, post-service cooldown, overdue flag and a saturating press counter.
module pedestrian_request_conditioner
  import ped_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int COOLDOWN_CYCLES = DEF_COOLDOWN_CYCLES,
  parameter int MAX_WAIT        = DEF_MAX_WAIT,
  parameter int COUNT_WIDTH     = DEF_COUNT_WIDTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   button_raw,
  input  logic                   served_green,
  output logic                   request,
  output logic                   wait_lamp,
  output logic                   overdue,
  output logic [COUNT_WIDTH-1:0] press_count
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam int COOL_W = $clog2(COOLDOWN_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MAX_WAIT);
  localparam logic [COOL_W-1:0] COOL_LOAD = COOL_W'(COOLDOWN_CYCLES - 1);

  ped_state_t        state;
  ped_state_t        state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic [COOL_W-1:0] cool_cnt;
  logic              pending;
  logic              press;
  logic              stable_unused;
  logic              arming;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_button_debouncer (
    .clock     (clock),
    .reset     (reset),
    .button_raw(button_raw),
    .stable    (stable_unused),
    .press     (press)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: default assignment first so every path drives state_next and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (press) state_next = ARMED;
      ARMED:    if (served_green) state_next = SERVING;
      SERVING:  if (!served_green) state_next = COOLDOWN;
      COOLDOWN: if (cool_cnt == '0) state_next = (pending || press) ? ARMED : IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Only fresh arrivals count; ARMED never re-enters itself.
  assign arming = (state_next == ARMED) && (state == IDLE || state == COOLDOWN);

  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt    <= '0;
      cool_cnt    <= '0;
      pending     <= 1'b0;
      press_count <= '0;
    end else begin
      if (state == ARMED) begin
        if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end

      if (state == SERVING && !served_green) begin
        cool_cnt <= COOL_LOAD;
        pending  <= 1'b0;
      end else if (state == COOLDOWN) begin
        if (cool_cnt != '0) cool_cnt <= cool_cnt - 1'b1;
        if (press)          pending  <= 1'b1;
      end

      if (arming && press_count != '1) press_count <= press_count + 1'b1;
    end
  end

  always_comb begin
    request   = (state == ARMED);
    wait_lamp = (state == ARMED) || (state == COOLDOWN && pending);
    overdue   = (state == ARMED) && (wait_cnt == WAIT_MAX);
  end

endmodule

// File: tb/tb_pedestrian_request_conditioner.sv
// Self-checking bench for pedestrian_request_conditioner: a segment table of per-edge
// expectations feeds a scoreboard queue that a monitor drains one edge at a time.
module tb_pedestrian_request_conditioner;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       button_raw = 1'b0;
  logic       served_green = 1'b0;
  logic       request;
  logic       wait_lamp;
  logic       overdue;
  logic [1:0] press_count;

  pedestrian_request_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .COOLDOWN_CYCLES(3),
    .MAX_WAIT       (10),
    .COUNT_WIDTH    (2)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .button_raw  (button_raw),
    .served_green(served_green),
    .request     (request),
    .wait_lamp   (wait_lamp),
    .overdue     (overdue),
    .press_count (press_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    string    name;
    bit       req;
    bit       wl;
    bit       od;
    bit [1:0] cnt;
  } exp_t;

  typedef struct {
    string    name;
    bit       rst;
    bit       btn;
    bit       srv;
    int       reps;
    bit       req;
    bit       wl;
    bit       od;
    bit [1:0] cnt;
  } seg_t;

  exp_t sb[$];
  seg_t segs[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, got, want);
    end
  endtask

  // Each expectation describes the outputs just after the edge that samples its inputs.
  always @(posedge clock) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      check({mon_e.name, ".request"},     32'(request),     32'(mon_e.req));
      check({mon_e.name, ".wait_lamp"},   32'(wait_lamp),   32'(mon_e.wl));
      check({mon_e.name, ".overdue"},     32'(overdue),     32'(mon_e.od));
      check({mon_e.name, ".press_count"}, 32'(press_count), 32'(mon_e.cnt));
    end
  end

  task automatic step(input bit r, input bit b, input bit s, input exp_t e);
    @(negedge clock);
    reset        = r;
    button_raw   = b;
    served_green = s;
    sb.push_back(e);
    @(posedge clock);
  endtask

  function automatic void seg(input string n, input bit r, input bit b, input bit s,
                              input int reps, input bit q, input bit w, input bit o,
                              input bit [1:0] c);
    segs.push_back('{n, r, b, s, reps, q, w, o, c});
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog t=%0t got=timeout want=finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    //   name           rst btn srv reps req wl od cnt
    seg("reset",         1,  0,  0,  2,  0,  0, 0, 0);
    // Short pulse and bounce train: never DEBOUNCE_CYCLES consecutive highs.
    seg("glitch3",       0,  1,  0,  3,  0,  0, 0, 0);
    seg("glitch_gap",    0,  0,  0,  3,  0,  0, 0, 0);
    for (int i = 0; i < 6; i++) seg("bounce", 0, (i % 2) == 0, 0, 1, 0, 0, 0, 0);
    seg("settle",        0,  0,  0,  4,  0,  0, 0, 0);
    // Held press: request from the 6th sampling edge.
    seg("debouncing",    0,  1,  0,  5,  0,  0, 0, 0);
    seg("armed",         0,  1,  0,  3,  1,  1, 0, 1);
    seg("serving",       0,  0,  1, 10,  0,  0, 0, 1);
    seg("cooldown_idle", 0,  0,  0,  4,  0,  0, 0, 1);
    // Fresh press from IDLE, then hold unserved until overdue.
    seg("idle_deb",      0,  1,  0,  5,  0,  0, 0, 1);
    seg("armed2",        0,  1,  0,  1,  1,  1, 0, 2);
    seg("wait_pre",      0,  0,  0,  9,  1,  1, 0, 2);
    seg("overdue",       0,  0,  0,  3,  1,  1, 1, 2);
    seg("od_clear",      0,  0,  1,  2,  0,  0, 0, 2);
    // Press debounced one edge into COOLDOWN: pending lamp, then re-arm at expiry.
    seg("serve_btn",     0,  1,  1,  4,  0,  0, 0, 2);
    seg("cool_entry",    0,  1,  0,  1,  0,  0, 0, 2);
    seg("cool_pending",  0,  1,  0,  2,  0,  1, 0, 2);
    seg("cool_rearm",    0,  1,  0,  1,  1,  1, 0, 3);
    // Another arrival with the counter at all-ones must not wrap.
    seg("serve3",        0,  0,  1,  6,  0,  0, 0, 3);
    seg("cool3",         0,  0,  0,  4,  0,  0, 0, 3);
    seg("deb4",          0,  1,  0,  5,  0,  0, 0, 3);
    seg("saturated",     0,  1,  0,  2,  1,  1, 0, 3);

    foreach (segs[i]) begin
      for (int k = 0; k < segs[i].reps; k++) begin
        step(segs[i].rst, segs[i].btn, segs[i].srv,
             exp_t'{segs[i].name, segs[i].req, segs[i].wl, segs[i].od, segs[i].cnt});
      end
    end

    // Reset while ARMED and overdue, button still held: needs a full fresh debounce.
    repeat (8) step(0, 1, 0, exp_t'{"t6_armed", 1, 1, 0, 3});
    step(0, 1, 0, exp_t'{"t6_overdue", 1, 1, 1, 3});
    step(1, 1, 0, exp_t'{"t6_reset", 0, 0, 0, 0});
    repeat (5) step(0, 1, 0, exp_t'{"t6_redebounce", 0, 0, 0, 0});
    step(0, 1, 0, exp_t'{"t6_rearmed", 1, 1, 0, 1});

    @(negedge clock);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/pedestrian_request_conditioner.md
Name: pedestrian_request_conditioner

Overview:
- Upstream input stage for the intersection controller's pedestrian arbiter request.
- Synchronises and debounces the raw crossing button.
- Latches a debounced press as a level request held until the pedestrian phase is served (green observed).
- Drives the "WAIT" indicator, enforces a post-service cooldown, and flags requests left unserved too long.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive cycles the synchronised input must differ from the stable value before the stable value flips. Must be >= 1.
- COOLDOWN_CYCLES, 8, cycles after pedestrian green drops during which no new request is asserted. Must be >= 1.
- MAX_WAIT, 1024, cycles in ARMED after which overdue asserts. Must be >= 1.
- COUNT_WIDTH, 16, width of press_count.

Ports:
- clock  input  1  system clock; all state updates on its rising edge
- reset  input  1  synchronous, active-high reset
- button_raw  input  1  raw push-button, asynchronous to clock, may bounce
- served_green  input  1  pedestrian green from the intersection block
- request  output  1  level request to the intersection pedestrian arbiter input
- wait_lamp  output  1  "WAIT" indicator; high while a request is pending service
- overdue  output  1  high once ARMED has lasted MAX_WAIT cycles
- press_count  output  COUNT_WIDTH  accepted presses, saturating

Behaviour:
- Reset (sampled at an edge) clears everything:
  - request=0, wait_lamp=0, overdue=0, press_count=0
  - state=IDLE; sync flops=0; stable=0; debounce cnt=0; cooldown cnt=0; wait cnt=0; pending=0
  - Reset mid-operation aborts any request immediately; request is 0 in the cycle after the reset edge.
- Synchroniser: two flops, sync1 <= button_raw, sync2 <= sync1.
- Debounce (cnt width $clog2(DEBOUNCE_CYCLES+1)):
  - If sync2 == stable, cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: stable <= sync2 and cnt <= 0.
  - Otherwise cnt increments.
  - press = (flip condition) && sync2==1. It is a single-cycle pulse, combinational in the flip cycle.
- Latency: button_raw first sampled high at edge 0 and held gives press at edge DEBOUNCE_CYCLES+1. request is high from that edge.
- Any glitch shorter than DEBOUNCE_CYCLES cycles at sync2 produces no press.
- FSM states: IDLE, ARMED, SERVING, COOLDOWN.
  - IDLE: request=0, wait_lamp=0. On press -> ARMED. served_green while in IDLE is ignored.
  - ARMED: request=1, wait_lamp=1.
    - wait cnt increments, saturating at MAX_WAIT; overdue=1 when wait cnt == MAX_WAIT.
    - On served_green=1 -> SERVING. A press in the same cycle is dropped.
    - A press while ARMED has no effect.
  - SERVING: request=0, wait_lamp=0, overdue=0, wait cnt cleared.
    - Presses ignored.
    - On served_green=0 -> COOLDOWN with cooldown cnt loaded to COOLDOWN_CYCLES-1 and pending=0.
  - COOLDOWN: request=0, wait_lamp = pending.
    - A press sets pending.
    - When cooldown cnt == 0: -> ARMED if pending (or press this cycle), else -> IDLE.
    - Otherwise cooldown cnt decrements.
- press_count increments on every IDLE->ARMED or COOLDOWN->ARMED transition. It saturates at all-ones and never wraps.
- All outputs are registered or decoded from state only; no combinational path from button_raw or served_green to any output.

Decomposition:
- Shared package (ped_cond_pkg):
  - state enum: IDLE=0, ARMED=1, SERVING=2, COOLDOWN=3
  - default-parameter constants
- One sub-module: button_debouncer (synchroniser + debounce counter; outputs stable and the press pulse). Reusable later for the turn_sensor input.

Test Plan (DEBOUNCE_CYCLES=4, COOLDOWN_CYCLES=3, MAX_WAIT=10):
1. button_raw high from edge 0, held -> request=1 and wait_lamp=1 from edge 5; press_count=1.
2. button_raw pulses high for 3 cycles, plus a bounce train of 1-cycle pulses -> request stays 0, press_count=0.
3. ARMED, served_green high edges 20-29 -> request=0 from edge 20. COOLDOWN entered at edge 30; IDLE at edge 33 with no press.
4. Debounced press landing in COOLDOWN at edge 31 -> wait_lamp=1 at edge 31; ARMED and request=1 at edge 33; press_count=2.
5. ARMED with served_green held 0 -> overdue=1 exactly 10 cycles after ARMED entry. Clears the edge served_green rises.
6. reset asserted for one edge while ARMED with overdue=1 -> next cycle request=0, overdue=0, press_count=0, state IDLE. A held button re-arms only after a fresh debounce (DEBOUNCE_CYCLES+2 edges).
